// File: rtl/seg_display_sched_if.sv
// Requester-to-display bundle for the seven-segment scheduler.
// The master side drives requests; the slave side owns grant and digits.
interface seg_display_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] req_val;
    logic [NREQ-1:0]    grant;
    logic               gnt_pls;
    logic [3:0]         num1;
    logic [3:0]         num2;
    logic [3:0]         num3;
    logic [3:0]         num4;

    modport master (
        output req, req_val,
        input  grant, gnt_pls, num1, num2, num3, num4
    );

    modport slave (
        input  req, req_val,
        output grant, gnt_pls, num1, num2, num3, num4
    );
endinterface

// File: rtl/seg_display_sched.sv
// Round-robin time-sharing of the 4-digit hex display between NREQ sources.
// Each grant is held at least HOLD_CYCLES cycles unless its owner lets go.
module seg_display_sched #(
    parameter int NREQ        = 4,
    parameter int CNT_W       = 24,
    parameter int HOLD_CYCLES = 12_000_000
) (
    input  logic             clk,
    input  logic             rst,
    seg_display_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             pls_q, pls_d;
    logic [15:0]      num_q, num_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  cand;
    logic [IW-1:0]    win_idx;
    logic             win_vld;
    logic             own_req;
    logic             expired;

    // In HOLD the pointer always names the owner, so it is masked out
    assign cand    = (state_q == S_HOLD) ? (bus.req & ~grant_q) : bus.req;
    assign own_req = bus.req[ptr_q];
    assign expired = (cnt_q == HOLD_MAX);

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            int j;
            j = (int'(ptr_q) + i) % NREQ;
            if (cand[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pls_d   = 1'b0;
        num_d   = num_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_HOLD;
                    grant_d = NREQ'(1) << win_idx;
                    pls_d   = 1'b1;
                    num_d   = bus.req_val[16*int'(win_idx) +: 16];
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if ((!own_req || expired) && win_vld) begin
                    grant_d = NREQ'(1) << win_idx;
                    pls_d   = 1'b1;
                    num_d   = bus.req_val[16*int'(win_idx) +: 16];
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end else if (!own_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    num_d = bus.req_val[16*int'(ptr_q) +: 16];
                    if (!expired) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            pls_q   <= 1'b0;
            num_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pls_q   <= pls_d;
            num_q   <= num_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.gnt_pls = pls_q;
    assign bus.num1    = num_q[3:0];
    assign bus.num2    = num_q[7:4];
    assign bus.num3    = num_q[11:8];
    assign bus.num4    = num_q[15:12];
endmodule
